dma_bus_arbiter: RTL and testbench

- Shares the single 16-bit memory port between the CPU datapath and one external DMA/IO master.
- On a DMA request it asserts o_IOPAUSE to the clock divisor (i_IOPAUSE input) and waits for the divisor to report a halt at an instruction boundary.
- It then grants a bounded burst to the DMA master, returns the port to the CPU, and enforces a CPU hold-off window so the CPU cannot be starved.
- Sits between CPU memory muxes and the Memory block.

---
 rtl/dma_bus_arbiter_pkg.sv | 24 ++
 rtl/dma_bus_arbiter_if.sv | 25 ++
 rtl/dma_holdoff_counter.sv | 32 +++
 rtl/dma_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_dma_bus_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types for the memory-port arbiter and the IO blocks that sit beside it.
package dma_bus_arbiter_pkg;

  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPauseReq,
    StGrant,
    StRelease
  } arb_state_e;

  typedef enum logic {
    SelCpu,
    SelDma
  } mem_sel_e;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// DMA master beat handshake; the master drives requests, the arbiter answers.
interface dma_bus_arbiter_if;
  import dma_bus_arbiter_pkg::*;

  logic             req;
  logic             write;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] wdata;
  logic             last;
  logic             gnt;
  logic             ack;
  logic [DataW-1:0] rdata;
  logic             rvalid;

  modport master (
    output req, write, addr, wdata, last,
    input  gnt, ack, rdata, rvalid
  );

  modport slave (
    input  req, write, addr, wdata, last,
    output gnt, ack, rdata, rvalid
  );

endinterface

// File: rtl/dma_holdoff_counter.sv
// Counts completed CPU instructions after a DMA grant before another grant may start.
module dma_holdoff_counter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int unsigned HOLDOFF = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int unsigned     CntW    = clog2_min1(HOLDOFF + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(HOLDOFF);

  logic [CntW-1:0] r_count;

  // A load wins over a coincident decrement so the full window is always served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LoadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CntW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the memory port between the CPU and one DMA master: pause handshake,
// bounded burst grant, then a CPU hold-off window before the next grant.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic              i_CLOCK,
  input  logic              i_RESETN,
  dma_bus_arbiter_if.slave  dma,
  input  logic [AddrW-1:0]  i_CPU_RADDR,
  input  logic [AddrW-1:0]  i_CPU_WADDR,
  input  logic [DataW-1:0]  i_CPU_WDATA,
  input  logic              i_CPU_WRITE,
  input  logic              i_PAUSED,
  input  logic              i_INSTR_DONE,
  output logic              o_IOPAUSE,
  output logic [AddrW-1:0]  o_MEM_RADDR,
  output logic [AddrW-1:0]  o_MEM_WADDR,
  output logic [DataW-1:0]  o_MEM_WDATA,
  output logic              o_MEM_WRITE,
  input  logic [DataW-1:0]  i_MEM_RDATA
);

  localparam int unsigned       BurstW    = $clog2(MAX_BURST + 1);
  localparam logic [BurstW-1:0] MaxBurstC = BurstW'(MAX_BURST);

  arb_state_e        r_state;
  logic              r_iopause;
  logic              r_gnt;
  logic              r_rvalid;
  logic [BurstW-1:0] r_burst_cnt;

  logic              w_ack;
  logic              w_holdoff_zero;
  logic [BurstW-1:0] w_cnt_next;
  mem_sel_e          w_sel;

  assign w_ack      = r_gnt & dma.req;
  assign w_cnt_next = r_burst_cnt + BurstW'(1);
  assign w_sel      = (r_state == StGrant) ? SelDma : SelCpu;

  dma_holdoff_counter #(
    .HOLDOFF (HOLDOFF)
  ) u_holdoff (
    .i_clk   (i_CLOCK),
    .i_rst_n (i_RESETN),
    .i_load  (r_state == StRelease),
    .i_dec   (i_INSTR_DONE),
    .o_zero  (w_holdoff_zero)
  );

  always_ff @(posedge i_CLOCK or negedge i_RESETN) begin
    if (!i_RESETN) begin
      r_state     <= StIdle;
      r_iopause   <= 1'b0;
      r_gnt       <= 1'b0;
      r_rvalid    <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      // Memory read data arrives one cycle after the accepted read beat.
      r_rvalid <= w_ack & ~dma.write;
      case (r_state)
        StIdle: begin
          if (dma.req && w_holdoff_zero) begin
            r_state   <= StPauseReq;
            r_iopause <= 1'b1;
          end
        end
        StPauseReq: begin
          if (!dma.req) begin
            r_state   <= StIdle;
            r_iopause <= 1'b0;
          end else if (i_PAUSED) begin
            r_state <= StGrant;
            r_gnt   <= 1'b1;
          end
        end
        StGrant: begin
          if (!dma.req) begin
            r_state <= StRelease;
            r_gnt   <= 1'b0;
          end else begin
            r_burst_cnt <= w_cnt_next;
            if (dma.last || (w_cnt_next == MaxBurstC)) begin
              r_state <= StRelease;
              r_gnt   <= 1'b0;
            end
          end
        end
        StRelease: begin
          r_state     <= StIdle;
          r_iopause   <= 1'b0;
          r_burst_cnt <= '0;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_IOPAUSE  = r_iopause;
  assign dma.gnt    = r_gnt;
  assign dma.ack    = w_ack;
  assign dma.rvalid = r_rvalid;
  assign dma.rdata  = r_rvalid ? i_MEM_RDATA : '0;

  // CPU writes are blocked entirely while the DMA master owns the port.
  always_comb begin
    o_MEM_RADDR = i_CPU_RADDR;
    o_MEM_WADDR = i_CPU_WADDR;
    o_MEM_WDATA = i_CPU_WDATA;
    o_MEM_WRITE = i_CPU_WRITE;
    if (w_sel == SelDma) begin
      o_MEM_RADDR = dma.addr;
      o_MEM_WADDR = dma.addr;
      o_MEM_WDATA = dma.wdata;
      o_MEM_WRITE = dma.write & w_ack;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench: main arbiter (MAX_BURST=8, HOLDOFF=4) plus a HOLDOFF=0 instance.
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        paused = 1'b0;
  logic        paused0 = 1'b0;
  logic        instr_done = 1'b0;
  logic [15:0] cpu_raddr = 16'h0;
  logic [15:0] cpu_waddr = 16'h0;
  logic [15:0] cpu_wdata = 16'h0;
  logic        cpu_write = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] mem_rdata0 = 16'h0;
  logic        iopause, iopause0;
  logic [15:0] mem_raddr, mem_waddr, mem_wdata;
  logic [15:0] mem0_raddr, mem0_waddr, mem0_wdata;
  logic        mem_write, mem0_write;

  int n_checks = 0;
  int n_pass = 0;
  int acks;

  always #5 clk = ~clk;

  // Memory model: synchronous read, data is a fixed function of the address.
  always @(posedge clk) mem_rdata <= mem_raddr ^ 16'hA5A5;

  dma_bus_arbiter_if u_bus ();
  dma_bus_arbiter_if u_bus0 ();

  dma_bus_arbiter #(.MAX_BURST(8), .HOLDOFF(4)) u_dut (
    .i_CLOCK(clk), .i_RESETN(rst_n), .dma(u_bus),
    .i_CPU_RADDR(cpu_raddr), .i_CPU_WADDR(cpu_waddr), .i_CPU_WDATA(cpu_wdata),
    .i_CPU_WRITE(cpu_write), .i_PAUSED(paused), .i_INSTR_DONE(instr_done),
    .o_IOPAUSE(iopause), .o_MEM_RADDR(mem_raddr), .o_MEM_WADDR(mem_waddr),
    .o_MEM_WDATA(mem_wdata), .o_MEM_WRITE(mem_write), .i_MEM_RDATA(mem_rdata)
  );

  dma_bus_arbiter #(.MAX_BURST(8), .HOLDOFF(0)) u_dut0 (
    .i_CLOCK(clk), .i_RESETN(rst_n), .dma(u_bus0),
    .i_CPU_RADDR(cpu_raddr), .i_CPU_WADDR(cpu_waddr), .i_CPU_WDATA(cpu_wdata),
    .i_CPU_WRITE(cpu_write), .i_PAUSED(paused0), .i_INSTR_DONE(instr_done),
    .o_IOPAUSE(iopause0), .o_MEM_RADDR(mem0_raddr), .o_MEM_WADDR(mem0_waddr),
    .o_MEM_WDATA(mem0_wdata), .o_MEM_WRITE(mem0_write), .i_MEM_RDATA(mem_rdata0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_instr(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      instr_done = 1'b1;
      step();
      instr_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_bus.req = 1'b0; u_bus.write = 1'b0; u_bus.addr = 16'h0; u_bus.wdata = 16'h0;
    u_bus.last = 1'b0;
    u_bus0.req = 1'b0; u_bus0.write = 1'b0; u_bus0.addr = 16'h0; u_bus0.wdata = 16'h0;
    u_bus0.last = 1'b0;
    cpu_write = 1'b1; cpu_waddr = 16'h1234; cpu_raddr = 16'h4321;
    #2;
    n_checks++; if (iopause !== 1'b0) $display("FAIL rst_iopause: got %b want 0", iopause);
    else n_pass++;
    n_checks++; if (u_bus.gnt !== 1'b0) $display("FAIL rst_gnt: got %b want 0", u_bus.gnt);
    else n_pass++;
    n_checks++; if (u_bus.rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", u_bus.rvalid);
    else n_pass++;
    n_checks++; if (u_bus.rdata !== 16'h0) $display("FAIL rst_rdata: got %h want 0000", u_bus.rdata);
    else n_pass++;
    n_checks++; if (mem_write !== 1'b1) $display("FAIL rst_mux_write: got %b want 1", mem_write);
    else n_pass++;
    n_checks++; if (mem_raddr !== 16'h4321) $display("FAIL rst_mux_raddr: got %h want 4321", mem_raddr);
    else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    cpu_write = 1'b0;
  endtask

  task automatic test_read_burst();
    step();
    u_bus.req = 1'b1; u_bus.write = 1'b0; u_bus.addr = 16'h0100; u_bus.last = 1'b0;
    @(negedge clk);
    n_checks++; if (iopause !== 1'b0) $display("FAIL rd_idle_iopause: got %b want 0", iopause);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (iopause !== 1'b1) $display("FAIL rd_iopause_up: got %b want 1", iopause);
    else n_pass++;
    step();
    paused = 1'b1;
    @(negedge clk);
    n_checks++; if (u_bus.gnt !== 1'b0) $display("FAIL rd_gnt_early: got %b want 0", u_bus.gnt);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (u_bus.ack !== 1'b1) $display("FAIL rd_ack1: got %b want 1", u_bus.ack);
    else n_pass++;
    n_checks++; if (mem_raddr !== 16'h0100) $display("FAIL rd_raddr1: got %h want 0100", mem_raddr);
    else n_pass++;
    step();
    u_bus.addr = 16'h0101;
    @(negedge clk);
    n_checks++; if (u_bus.ack !== 1'b1) $display("FAIL rd_ack2: got %b want 1", u_bus.ack);
    else n_pass++;
    n_checks++; if (u_bus.rvalid !== 1'b1 || u_bus.rdata !== (16'h0100 ^ 16'hA5A5))
      $display("FAIL rd_data1: got v=%b d=%h want v=1 d=%h", u_bus.rvalid, u_bus.rdata,
               16'h0100 ^ 16'hA5A5);
    else n_pass++;
    step();
    u_bus.addr = 16'h0102; u_bus.last = 1'b1;
    @(negedge clk);
    n_checks++; if (u_bus.ack !== 1'b1) $display("FAIL rd_ack3: got %b want 1", u_bus.ack);
    else n_pass++;
    n_checks++; if (u_bus.rdata !== (16'h0101 ^ 16'hA5A5))
      $display("FAIL rd_data2: got %h want %h", u_bus.rdata, 16'h0101 ^ 16'hA5A5);
    else n_pass++;
    step();
    u_bus.req = 1'b0; u_bus.last = 1'b0;
    @(negedge clk);
    n_checks++; if (u_bus.gnt !== 1'b0 || u_bus.ack !== 1'b0 || iopause !== 1'b1)
      $display("FAIL rd_release: got gnt=%b ack=%b iop=%b want 0 0 1", u_bus.gnt, u_bus.ack,
               iopause);
    else n_pass++;
    n_checks++; if (u_bus.rvalid !== 1'b1 || u_bus.rdata !== (16'h0102 ^ 16'hA5A5))
      $display("FAIL rd_data3: got v=%b d=%h want v=1 d=%h", u_bus.rvalid, u_bus.rdata,
               16'h0102 ^ 16'hA5A5);
    else n_pass++;
    step();
    paused = 1'b0; u_bus.req = 1'b1;
    @(negedge clk);
    n_checks++; if (iopause !== 1'b0 || u_bus.rvalid !== 1'b0)
      $display("FAIL rd_idle_after: got iop=%b rv=%b want 0 0", iopause, u_bus.rvalid);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (iopause !== 1'b0) $display("FAIL rd_holdoff_pending: got %b want 0", iopause);
    else n_pass++;
    step();
    u_bus.req = 1'b0;
    pulse_instr(4);
  endtask

  task automatic test_max_burst();
    logic exp_ack;
    step();
    u_bus.req = 1'b1; u_bus.write = 1'b0; u_bus.addr = 16'h0200; u_bus.last = 1'b0;
    step();
    paused = 1'b1;
    @(negedge clk);
    n_checks++; if (iopause !== 1'b1) $display("FAIL mb_iopause: got %b want 1", iopause);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      step();
      u_bus.addr = 16'h0200 + 16'(i);
      if (i == 8) paused = 1'b0;
      @(negedge clk);
      exp_ack = (i < 8);
      n_checks++; if (u_bus.ack !== exp_ack)
        $display("FAIL mb_ack[%0d]: got %b want %b", i, u_bus.ack, exp_ack);
      else n_pass++;
    end
    n_checks++; if (u_bus.gnt !== 1'b0 || iopause !== 1'b0)
      $display("FAIL mb_after: got gnt=%b iop=%b want 0 0", u_bus.gnt, iopause);
    else n_pass++;
    for (int p = 0; p < 4; p++) begin
      step();
      instr_done = 1'b1;
      @(negedge clk);
      n_checks++; if (iopause !== 1'b0 || u_bus.ack !== 1'b0)
        $display("FAIL mb_hold[%0d]: got iop=%b ack=%b want 0 0", p, iopause, u_bus.ack);
      else n_pass++;
      step();
      instr_done = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (iopause !== 1'b0) $display("FAIL mb_rearm_lat: got %b want 0", iopause);
    else n_pass++;
    step();
    paused = 1'b1;
    @(negedge clk);
    n_checks++; if (iopause !== 1'b1) $display("FAIL mb_rearm: got %b want 1", iopause);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (u_bus.ack !== 1'b1) $display("FAIL mb_regrant: got %b want 1", u_bus.ack);
    else n_pass++;
    step();
    u_bus.req = 1'b0;
    @(negedge clk);
    n_checks++; if (u_bus.ack !== 1'b0) $display("FAIL mb_req_drop: got %b want 0", u_bus.ack);
    else n_pass++;
    step();
    paused = 1'b0;
    @(negedge clk);
    n_checks++; if (u_bus.gnt !== 1'b0 || iopause !== 1'b1)
      $display("FAIL mb_drop_release: got gnt=%b iop=%b want 0 1", u_bus.gnt, iopause);
    else n_pass++;
    pulse_instr(4);
  endtask

  task automatic test_cancel();
    step();
    u_bus.req = 1'b1; u_bus.addr = 16'h0; u_bus.last = 1'b0; u_bus.write = 1'b0;
    step();
    u_bus.req = 1'b0;
    @(negedge clk);
    n_checks++; if (iopause !== 1'b1 || u_bus.gnt !== 1'b0)
      $display("FAIL cn_pause: got iop=%b gnt=%b want 1 0", iopause, u_bus.gnt);
    else n_pass++;
    step();
    u_bus.req = 1'b1;
    @(negedge clk);
    n_checks++; if (iopause !== 1'b0) $display("FAIL cn_drop: got %b want 0", iopause);
    else n_pass++;
    step();
    u_bus.req = 1'b0; paused = 1'b1;
    @(negedge clk);
    n_checks++; if (iopause !== 1'b1) $display("FAIL cn_no_holdoff: got %b want 1", iopause);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (u_bus.gnt !== 1'b0 || iopause !== 1'b0 || u_bus.ack !== 1'b0)
      $display("FAIL cn_simul: got gnt=%b iop=%b ack=%b want 0 0 0", u_bus.gnt, iopause,
               u_bus.ack);
    else n_pass++;
    step();
    paused = 1'b0;
  endtask

  task automatic test_cpu_isolation();
    step();
    cpu_write = 1'b1; cpu_waddr = 16'h0020; cpu_wdata = 16'hBEEF; cpu_raddr = 16'h0055;
    u_bus.req = 1'b1; u_bus.write = 1'b0; u_bus.addr = 16'h0300; u_bus.last = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_waddr !== 16'h0020 || mem_wdata !== 16'hBEEF)
      $display("FAIL iso_idle: got w=%b a=%h d=%h want 1 0020 beef", mem_write, mem_waddr,
               mem_wdata);
    else n_pass++;
    step();
    paused = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1) $display("FAIL iso_pausereq: got %b want 1", mem_write);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b0 || mem_raddr !== 16'h0300)
      $display("FAIL iso_grant_read: got w=%b ra=%h want 0 0300", mem_write, mem_raddr);
    else n_pass++;
    step();
    u_bus.write = 1'b1; u_bus.addr = 16'h0301; u_bus.wdata = 16'hCAFE; u_bus.last = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_waddr !== 16'h0301 || mem_wdata !== 16'hCAFE)
      $display("FAIL iso_dma_write: got w=%b a=%h d=%h want 1 0301 cafe", mem_write,
               mem_waddr, mem_wdata);
    else n_pass++;
    step();
    u_bus.req = 1'b0; u_bus.write = 1'b0; u_bus.last = 1'b0; paused = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_waddr !== 16'h0020)
      $display("FAIL iso_release: got w=%b a=%h want 1 0020", mem_write, mem_waddr);
    else n_pass++;
    step();
    cpu_write = 1'b0;
    pulse_instr(4);
  endtask

  task automatic test_async_reset();
    step();
    u_bus.req = 1'b1; u_bus.write = 1'b0; u_bus.addr = 16'h0400; u_bus.last = 1'b0;
    step();
    paused = 1'b1;
    step();
    step();
    u_bus.addr = 16'h0401;
    @(negedge clk);
    n_checks++; if (u_bus.ack !== 1'b1) $display("FAIL ar_beat2: got %b want 1", u_bus.ack);
    else n_pass++;
    step();
    u_bus.addr = 16'h0402;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (u_bus.gnt !== 1'b0 || iopause !== 1'b0 || u_bus.rvalid !== 1'b0 ||
                    u_bus.rdata !== 16'h0)
      $display("FAIL ar_abort: got gnt=%b iop=%b rv=%b rd=%h want 0 0 0 0000", u_bus.gnt,
               iopause, u_bus.rvalid, u_bus.rdata);
    else n_pass++;
    paused = 1'b0;
    step();
    rst_n = 1'b1;
    u_bus.addr = 16'h0400;
    @(negedge clk);
    n_checks++; if (iopause !== 1'b0) $display("FAIL ar_idle: got %b want 0", iopause);
    else n_pass++;
    step();
    paused = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      u_bus.addr = 16'h0400 + 16'(i);
      if (i == 8) paused = 1'b0;
      @(negedge clk);
      if (u_bus.ack === 1'b1) acks++;
    end
    n_checks++; if (acks != 8) $display("FAIL ar_full_burst: got %0d beats want 8", acks);
    else n_pass++;
    u_bus.req = 1'b0;
    pulse_instr(4);
  endtask

  task automatic test_holdoff_coincidence();
    step();
    u_bus.req = 1'b1; u_bus.write = 1'b0; u_bus.addr = 16'h0500; u_bus.last = 1'b1;
    step();
    paused = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (u_bus.ack !== 1'b1) $display("FAIL hc_beat: got %b want 1", u_bus.ack);
    else n_pass++;
    step();
    instr_done = 1'b1; u_bus.last = 1'b0; paused = 1'b0;
    @(negedge clk);
    n_checks++; if (u_bus.gnt !== 1'b0 || iopause !== 1'b1)
      $display("FAIL hc_release: got gnt=%b iop=%b want 0 1", u_bus.gnt, iopause);
    else n_pass++;
    step();
    instr_done = 1'b0;
    pulse_instr(3);
    step();
    @(negedge clk);
    n_checks++; if (iopause !== 1'b0) $display("FAIL hc_not_early: got %b want 0", iopause);
    else n_pass++;
    pulse_instr(1);
    step();
    @(negedge clk);
    n_checks++; if (iopause !== 1'b1) $display("FAIL hc_rearm: got %b want 1", iopause);
    else n_pass++;
    step();
    u_bus.req = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if (iopause !== 1'b0) $display("FAIL hc_cancel: got %b want 0", iopause);
    else n_pass++;
  endtask

  task automatic test_holdoff_zero();
    step();
    u_bus0.req = 1'b1; u_bus0.write = 1'b0; u_bus0.addr = 16'h0600; u_bus0.last = 1'b1;
    step();
    paused0 = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (u_bus0.ack !== 1'b1) $display("FAIL hz_beat: got %b want 1", u_bus0.ack);
    else n_pass++;
    step();
    paused0 = 1'b0;
    @(negedge clk);
    n_checks++; if (u_bus0.gnt !== 1'b0 || iopause0 !== 1'b1)
      $display("FAIL hz_release: got gnt=%b iop=%b want 0 1", u_bus0.gnt, iopause0);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (iopause0 !== 1'b0) $display("FAIL hz_idle: got %b want 0", iopause0);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (iopause0 !== 1'b1) $display("FAIL hz_reenter: got %b want 1", iopause0);
    else n_pass++;
    step();
    u_bus0.req = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if (iopause0 !== 1'b0) $display("FAIL hz_cancel: got %b want 0", iopause0);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_burst();
    test_max_burst();
    test_cancel();
    test_cpu_isolation();
    test_async_reset();
    test_holdoff_coincidence();
    test_holdoff_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
